// File: rtl/snake_box_mover.sv
// snake_box_mover: steers the snake-head box from four buttons and steps it once every MOVE_FRAMES frames.
//   I_clk, I_rst (async, active-high)
//   I_btn_up/down/left/right : raw buttons, synchronized and edge-detected here
//   I_vs                     : vga_driver O_vs, active-low sync pulse, frame reference
//   O_box_x, O_box_y         : box top-left corner, wraps at the screen edges
//   O_dir                    : heading 0 STOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT
//   O_moving                 : high whenever the heading is not STOP
module snake_box_mover #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BOX_SIZE    = 16,
  parameter int STEP        = 16,
  parameter int MOVE_FRAMES = 8,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_btn_up,
  input  logic       I_btn_down,
  input  logic       I_btn_left,
  input  logic       I_btn_right,
  input  logic       I_vs,
  output logic [9:0] O_box_x,
  output logic [9:0] O_box_y,
  output logic [2:0] O_dir,
  output logic       O_moving
);
  typedef enum logic [2:0] {STOP, UP, DOWN, LEFT, RIGHT} dir_t;
  localparam int CW = MOVE_FRAMES > 1 ? $clog2(MOVE_FRAMES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MOVE_FRAMES - 1);
  localparam logic [10:0] XMAX = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] YMAX = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STP = 11'(STEP);
  logic [3:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, pulse;
  logic vs_q, vs_d, tick, step, vert_w, vert_c;
  dir_t dir_q, dir_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [10:0] xp, yp;
  always_comb begin
    s1_d = {I_btn_right, I_btn_left, I_btn_down, I_btn_up};
    s2_d = s1_q;
    prev_d = s2_q;
    vs_d = I_vs;
    pulse = s2_q & ~prev_q;
    win = pulse[0] ? UP : pulse[1] ? DOWN : pulse[2] ? LEFT : pulse[3] ? RIGHT : STOP;
    // a press is accepted from STOP or when it turns the heading by 90 degrees
    vert_w = win == UP || win == DOWN;
    vert_c = dir_q == UP || dir_q == DOWN;
    dir_d = (win != STOP && (dir_q == STOP || vert_w != vert_c)) ? win : dir_q;
    // tick marks the rising edge of I_vs, i.e. the end of vertical sync
    tick = I_vs & ~vs_q;
    step = dir_q != STOP && tick && cnt_q == CMAX;
    cnt_d = dir_q == STOP ? '0 : !tick ? cnt_q : cnt_q == CMAX ? '0 : cnt_q + CW'(1);
    xp = {1'b0, x_q} + STP;
    yp = {1'b0, y_q} + STP;
    x_d = !step ? x_q :
          dir_q == RIGHT ? (xp > XMAX ? '0 : xp[9:0]) :
          dir_q == LEFT  ? ({1'b0, x_q} < STP ? XMAX[9:0] : x_q - STP[9:0]) : x_q;
    y_d = !step ? y_q :
          dir_q == DOWN ? (yp > YMAX ? '0 : yp[9:0]) :
          dir_q == UP   ? ({1'b0, y_q} < STP ? YMAX[9:0] : y_q - STP[9:0]) : y_q;
  end
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
      vs_q <= 1'b0;
      dir_q <= STOP;
      cnt_q <= '0;
      x_q <= 10'(X_INIT);
      y_q <= 10'(Y_INIT);
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      prev_q <= prev_d;
      vs_q <= vs_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assign O_box_x = x_q;
  assign O_box_y = y_q;
  assign O_dir = dir_q;
  assign O_moving = dir_q != STOP;
endmodule

// File: tb/tb_snake_box_mover.sv
// tb_snake_box_mover: directed bench for snake_box_mover with immediate-assertion checks.
module tb_snake_box_mover;
  logic clk = 1'b0, rst = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, vs = 1'b1;
  logic [9:0] bx, by;
  logic [2:0] dir;
  logic moving;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  snake_box_mover dut (
    .I_clk(clk), .I_rst(rst), .I_btn_up(up), .I_btn_down(down), .I_btn_left(left),
    .I_btn_right(right), .I_vs(vs), .O_box_x(bx), .O_box_y(by), .O_dir(dir), .O_moving(moving)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vs = 1'b0;
      repeat (2) @(negedge clk);
      vs = 1'b1;
      @(negedge clk);
    end
  endtask
  task automatic press(input logic [3:0] b);
    {up, down, left, right} = b;
    repeat (4) @(negedge clk);
    {up, down, left, right} = 4'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", bx, 320);
    chk("rst_y", by, 240);
    chk("rst_dir", dir, 0);
    chk("rst_moving", moving, 0);
    rst = 1'b0;
    frames(20);
    chk("idle_x", bx, 320);
    chk("idle_y", by, 240);
    chk("idle_moving", moving, 0);
    press(4'b0001);
    chk("right_dir", dir, 4);
    chk("right_moving", moving, 1);
    frames(7);
    chk("pre8_x", bx, 320);
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    #1 chk("tick8_before_edge_x", bx, 320);
    @(negedge clk);
    chk("step1_x", bx, 336);
    chk("step1_y", by, 240);
    frames(8);
    chk("step2_x", bx, 352);
    frames(8 * 17);
    chk("x_624", bx, 624);
    frames(8);
    chk("wrap_right_x", bx, 0);
    press(4'b1000);
    chk("up_dir", dir, 1);
    frames(8 * 15);
    chk("y_0", by, 0);
    frames(8);
    chk("wrap_up_y", by, 464);
    chk("wrap_up_x_hold", bx, 0);
    press(4'b0001);
    chk("turn_right_dir", dir, 4);
    press(4'b0010);
    chk("reverse_ignored_dir", dir, 4);
    press(4'b1100);
    chk("prio_up_dir", dir, 1);
    press(4'b0001);
    chk("turn_right2_dir", dir, 4);
    frames(7);
    up = 1'b1;
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
    chk("same_edge_x", bx, 16);
    chk("same_edge_y", by, 464);
    chk("same_edge_dir", dir, 1);
    up = 1'b0;
    frames(8);
    chk("next_step_y", by, 448);
    chk("next_step_x", bx, 16);
    left = 1'b1;
    repeat (10) @(negedge clk);
    chk("hold_left_dir", dir, 3);
    up = 1'b1;
    repeat (4) @(negedge clk);
    up = 1'b0;
    chk("hold_up_dir", dir, 1);
    repeat (86) @(negedge clk);
    chk("hold_once_dir", dir, 1);
    left = 1'b0;
    frames(3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_x", bx, 320);
    chk("async_y", by, 240);
    chk("async_dir", dir, 0);
    chk("async_moving", moving, 0);
    @(negedge clk);
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
